// File: rtl/cpu_isa_pkg.sv
// Opcode map, writeback FSM states and the writeback-enable rule for the writeback stage.
package cpu_isa_pkg;

  localparam int unsigned NOP   = 0;
  localparam int unsigned ADD   = 1;
  localparam int unsigned SUB   = 2;
  localparam int unsigned STORE = 3;
  localparam int unsigned LOAD  = 4;
  localparam int unsigned MOVE  = 5;
  localparam int unsigned AND   = 6;
  localparam int unsigned OR    = 7;
  localparam int unsigned XOR   = 8;
  localparam int unsigned NOT   = 9;
  localparam int unsigned SHL   = 10;
  localparam int unsigned SHR   = 11;
  localparam int unsigned SAR   = 12;
  localparam int unsigned MUL   = 13;
  localparam int unsigned DIV   = 14;
  localparam int unsigned MOD   = 15;
  localparam int unsigned MOVEI = 16;
  localparam int unsigned CMP   = 17;
  localparam int unsigned SLT   = 18;
  localparam int unsigned SLTU  = 19;
  localparam int unsigned LUI   = 20;
  localparam int unsigned JUMP  = 21;
  localparam int unsigned BRA   = 22;
  localparam int unsigned ADDF  = 23;
  localparam int unsigned MULF  = 24;

  typedef enum logic [0:0] {
    S_RUN,
    S_WAIT_DM
  } wb_state_t;

  // Unknown opcodes fall through to "writes", matching the ALUOUT default.
  function automatic logic wb_writes(input int unsigned opc);
    return !(opc == NOP || opc == STORE || opc == JUMP || opc == BRA);
  endfunction

endpackage

// File: rtl/wb_select_stage_if.sv
// Upstream, data-memory and writeback buses of wb_select_stage.
// fwd_* bypass signals exist only when WB_FWD_EN is defined.
interface wb_select_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OPC_W  = 6,
  parameter int unsigned REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  OPC;
  logic [REG_AW-1:0] RD;
  logic [DATA_W-1:0] RS1;
  logic [DATA_W-1:0] IMMVAL;
  logic [DATA_W-1:0] ALUOUT;
  logic              dm_valid;
  logic              dm_ready;
  logic [DATA_W-1:0] DOUT_DM;
  logic              out_valid;
  logic              out_ready;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_err;
`ifdef WB_FWD_EN
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, OPC, RD, RS1, IMMVAL, ALUOUT, dm_valid, DOUT_DM, out_ready,
    input  in_ready, dm_ready, out_valid, wb_we, wb_rd, wb_data, wb_err,
    input  fwd_valid, fwd_rd, fwd_data
  );
  modport slave (
    input  in_valid, OPC, RD, RS1, IMMVAL, ALUOUT, dm_valid, DOUT_DM, out_ready,
    output in_ready, dm_ready, out_valid, wb_we, wb_rd, wb_data, wb_err,
    output fwd_valid, fwd_rd, fwd_data
  );
`else
  modport master (
    output in_valid, OPC, RD, RS1, IMMVAL, ALUOUT, dm_valid, DOUT_DM, out_ready,
    input  in_ready, dm_ready, out_valid, wb_we, wb_rd, wb_data, wb_err
  );
  modport slave (
    input  in_valid, OPC, RD, RS1, IMMVAL, ALUOUT, dm_valid, DOUT_DM, out_ready,
    output in_ready, dm_ready, out_valid, wb_we, wb_rd, wb_data, wb_err
  );
`endif
endinterface

// File: rtl/wb_src_mux.sv
// Combinational opcode-to-source selector for writeback; also decides the register-file write enable.
module wb_src_mux
  import cpu_isa_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OPC_W  = 6
) (
  input  logic [OPC_W-1:0]  opc_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] alu_i,
  output logic [DATA_W-1:0] data_o,
  output logic              we_o
);

  always_comb begin
    data_o = alu_i;
    we_o   = wb_writes(32'(opc_i));
    if (opc_i == OPC_W'(MOVE)) begin
      data_o = rs1_i;
    end else if (opc_i == OPC_W'(MOVEI)) begin
      data_o = imm_i;
    end
  end

endmodule

// File: rtl/wb_select_stage.sv
// Registered writeback-select stage: selects the writeback source, stalls LOADs on data memory and
// flags LOADs that time out. Defining WB_FWD_EN adds fwd_* bypass outputs from the output register.
module wb_select_stage
  import cpu_isa_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned OPC_W        = 6,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input logic               clock,
  input logic               reset_n,
  wb_select_stage_if.slave  bus
);

  localparam int unsigned CntW        = (LOAD_TIMEOUT > 0) ? $clog2(LOAD_TIMEOUT + 1) : 1;
  localparam int unsigned TimeoutLast = (LOAD_TIMEOUT > 0) ? LOAD_TIMEOUT - 1 : 0;

  wb_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic              out_valid_q, out_valid_d;
  logic              wb_we_q, wb_we_d;
  logic              wb_err_q, wb_err_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              slot_free;
  logic              accept;
  logic              dm_hs;
  logic              is_load;
  logic              timeout_hit;
  logic [DATA_W-1:0] mux_data;
  logic              mux_we;

  wb_src_mux #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_src_mux (
    .opc_i  (bus.OPC),
    .rs1_i  (bus.RS1),
    .imm_i  (bus.IMMVAL),
    .alu_i  (bus.ALUOUT),
    .data_o (mux_data),
    .we_o   (mux_we)
  );

  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && (state_q == S_RUN) && slot_free;
  assign dm_hs     = bus.dm_valid && (state_q == S_WAIT_DM) && slot_free;
  assign is_load   = (bus.OPC == OPC_W'(LOAD));
  // Fires in the wait cycle whose increment would bring the count to LOAD_TIMEOUT.
  assign timeout_hit = (LOAD_TIMEOUT != 0) && (cnt_q >= CntW'(TimeoutLast));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_rd_d     = ld_rd_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    wb_we_d     = wb_we_q;
    wb_err_d    = wb_err_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          if (is_load) begin
            state_d = S_WAIT_DM;
            cnt_d   = '0;
            ld_rd_d = bus.RD;
          end else begin
            out_valid_d = 1'b1;
            wb_we_d     = mux_we;
            wb_err_d    = 1'b0;
            wb_rd_d     = bus.RD;
            wb_data_d   = mux_data;
          end
        end
      end
      S_WAIT_DM: begin
        if (dm_hs) begin
          out_valid_d = 1'b1;
          wb_we_d     = 1'b1;
          wb_err_d    = 1'b0;
          wb_rd_d     = ld_rd_q;
          wb_data_d   = bus.DOUT_DM;
          state_d     = S_RUN;
        end else if (timeout_hit && slot_free) begin
          out_valid_d = 1'b1;
          wb_we_d     = 1'b0;
          wb_err_d    = 1'b1;
          wb_rd_d     = ld_rd_q;
          wb_data_d   = '0;
          state_d     = S_RUN;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      ld_rd_q     <= '0;
      out_valid_q <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_rd_q     <= ld_rd_d;
      out_valid_q <= out_valid_d;
      wb_we_q     <= wb_we_d;
      wb_err_q    <= wb_err_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign bus.in_ready  = (state_q == S_RUN) && slot_free;
  assign bus.dm_ready  = (state_q == S_WAIT_DM) && slot_free;
  assign bus.out_valid = out_valid_q;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_err    = wb_err_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

`ifdef WB_FWD_EN
  assign bus.fwd_valid = out_valid_q && wb_we_q;
  assign bus.fwd_rd    = wb_rd_q;
  assign bus.fwd_data  = wb_data_q;
`endif

endmodule
